// File: rtl/dmac_ctrl_arbiter.sv
// Arbiter sharing one DMA control port among NB_REQ requesters, with in-order response routing.
// Define DMAC_CTRL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dmac_ctrl_arbiter #(
    parameter int NB_REQ          = 10,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_WIDTH        = $clog2(NB_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_REQ-1:0]                    req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]    add_i,
    input  logic [NB_REQ-1:0]                    wen_i,
    input  logic [NB_REQ-1:0][BE_WIDTH-1:0]      be_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NB_REQ-1:0]                    gnt_o,
    output logic [NB_REQ-1:0]                    r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,
    output logic                                 mst_req_o,
    output logic [ADDR_WIDTH-1:0]                mst_add_o,
    output logic                                 mst_wen_o,
    output logic [BE_WIDTH-1:0]                  mst_be_o,
    output logic [DATA_WIDTH-1:0]                mst_wdata_o,
    output logic [ID_WIDTH-1:0]                  mst_id_o,
    input  logic                                 mst_gnt_i,
    input  logic                                 mst_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                mst_r_rdata_i,
    input  logic                                 mst_r_opc_i,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_WIDTH-1:0] fifo_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                lock_r;
    logic [ID_WIDTH-1:0] lock_id_r;
    logic                err_r;
    logic [ID_WIDTH-1:0] rr_base_s;

    logic [ID_WIDTH-1:0] arb_id_s;
    logic                found_s;
    int                  idx_s;
    logic [ID_WIDTH-1:0] sel_id_s;
    logic                not_full_s;
    logic                mst_req_s;
    logic                push_s;
    logic                pop_s;
    logic [ID_WIDTH-1:0] head_s;

`ifdef DMAC_CTRL_ARB_FIXED_PRIO_EN
    assign rr_base_s = {ID_WIDTH{1'b0}};
`else
    logic [ID_WIDTH-1:0] rr_ptr_r;

    // Round-robin pointer moves just past the requester that completed a handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r <= {ID_WIDTH{1'b0}};
        end else if (push_s) begin
            rr_ptr_r <= (sel_id_s == ID_WIDTH'(NB_REQ - 1)) ? {ID_WIDTH{1'b0}}
                                                           : sel_id_s + ID_WIDTH'(1);
        end
    end

    assign rr_base_s = rr_ptr_r;
`endif

    // Cyclic search for the first requester at or after the base index.
    always_comb begin
        arb_id_s = {ID_WIDTH{1'b0}};
        found_s  = 1'b0;
        idx_s    = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx_s = int'(rr_base_s) + i;
            idx_s = (idx_s >= NB_REQ) ? idx_s - NB_REQ : idx_s;
            if (!found_s && req_i[idx_s]) begin
                found_s  = 1'b1;
                arb_id_s = ID_WIDTH'(idx_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // A pending, ungranted request keeps its winner until the handshake.
    assign sel_id_s   = lock_r ? lock_id_r : arb_id_s;
    assign not_full_s = (cnt_r < CNT_W'(MAX_OUTSTANDING));
    assign mst_req_s  = not_full_s & (lock_r | found_s);
    assign push_s     = mst_req_s & mst_gnt_i;
    assign head_s     = fifo_r[rd_ptr_r];
    assign pop_s      = mst_r_valid_i & (cnt_r != {CNT_W{1'b0}});

    assign mst_req_o   = mst_req_s;
    assign mst_id_o    = sel_id_s;
    assign mst_add_o   = add_i[sel_id_s];
    assign mst_wen_o   = wen_i[sel_id_s];
    assign mst_be_o    = be_i[sel_id_s];
    assign mst_wdata_o = wdata_i[sel_id_s];
    assign r_rdata_o   = mst_r_rdata_i;
    assign r_opc_o     = mst_r_opc_i;
    assign busy_o      = (cnt_r != {CNT_W{1'b0}});
    assign err_o       = err_r;

    // One-hot grant and response-valid decode.
    always_comb begin
        gnt_o     = {NB_REQ{1'b0}};
        r_valid_o = {NB_REQ{1'b0}};
        for (int i = 0; i < NB_REQ; i++) begin
            gnt_o[i]     = push_s && (sel_id_s == ID_WIDTH'(i));
            r_valid_o[i] = pop_s && (head_s == ID_WIDTH'(i));
        end
    end

    // ID FIFO, outstanding count, request lock and sticky orphan-response flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_r[i] <= {ID_WIDTH{1'b0}};
            end
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            lock_r    <= 1'b0;
            lock_id_r <= {ID_WIDTH{1'b0}};
            err_r     <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_id_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (push_s) begin
                lock_r <= 1'b0;
            end else if (mst_req_s) begin
                lock_r    <= 1'b1;
                lock_id_r <= sel_id_s;
            end
            if (mst_r_valid_i && !pop_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Directed, table-driven bench for dmac_ctrl_arbiter (default parameters, round-robin build).
module tb_dmac_ctrl_arbiter;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [9:0]         req_i;
    logic [9:0][31:0]   add_i;
    logic [9:0]         wen_i;
    logic [9:0][3:0]    be_i;
    logic [9:0][31:0]   wdata_i;
    logic [9:0]         gnt_o;
    logic [9:0]         r_valid_o;
    logic [31:0]        r_rdata_o;
    logic               r_opc_o;
    logic               mst_req_o;
    logic [31:0]        mst_add_o;
    logic               mst_wen_o;
    logic [3:0]         mst_be_o;
    logic [31:0]        mst_wdata_o;
    logic [3:0]         mst_id_o;
    logic               mst_gnt_i;
    logic               mst_r_valid_i;
    logic [31:0]        mst_r_rdata_i;
    logic               mst_r_opc_i;
    logic               busy_o;
    logic               err_o;

    int total = 0;
    int bad   = 0;

    dmac_ctrl_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .mst_req_o(mst_req_o),
        .mst_add_o(mst_add_o), .mst_wen_o(mst_wen_o), .mst_be_o(mst_be_o),
        .mst_wdata_o(mst_wdata_o), .mst_id_o(mst_id_o), .mst_gnt_i(mst_gnt_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_rdata_i(mst_r_rdata_i),
        .mst_r_opc_i(mst_r_opc_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [9:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic [9:0]  e_gnt;
        logic [9:0]  e_rv;
        logic        e_mreq;
        logic [3:0]  e_id;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [9:0] rq, input logic g, input logic rv,
                                input logic [31:0] rd, input logic [9:0] eg,
                                input logic [9:0] erv, input logic emr,
                                input logic [3:0] eid, input logic eb, input logic ee);
        vec_t v;
        v.req = rq; v.gnt = g; v.rv = rv; v.rdata = rd;
        v.e_gnt = eg; v.e_rv = erv; v.e_mreq = emr; v.e_id = eid;
        v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] rq, input logic g, input logic rv,
                         input logic [31:0] rd);
        req_i = rq; mst_gnt_i = g; mst_r_valid_i = rv;
        mst_r_rdata_i = rd; mst_r_opc_i = rd[0];
    endtask

    // Checks outputs 1 time unit after the inputs were driven, then advances one cycle.
    task automatic check(input string nm, input vec_t v);
        #1;
        cmp({nm, ".gnt"}, 32'(gnt_o), 32'(v.e_gnt));
        cmp({nm, ".r_valid"}, 32'(r_valid_o), 32'(v.e_rv));
        cmp({nm, ".mst_req"}, 32'(mst_req_o), 32'(v.e_mreq));
        if (v.e_mreq) begin
            cmp({nm, ".mst_id"}, 32'(mst_id_o), 32'(v.e_id));
            cmp({nm, ".mst_add"}, mst_add_o, add_i[v.e_id]);
            cmp({nm, ".mst_wdata"}, mst_wdata_o, wdata_i[v.e_id]);
        end
        if (v.rv) begin
            cmp({nm, ".r_rdata"}, r_rdata_o, v.rdata);
            cmp({nm, ".r_opc"}, 32'(r_opc_o), 32'(v.rdata[0]));
        end
        cmp({nm, ".busy"}, 32'(busy_o), 32'(v.e_busy));
        cmp({nm, ".err"}, 32'(err_o), 32'(v.e_err));
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic run(input string nm, input vec_t v);
        drive(v.req, v.gnt, v.rv, v.rdata);
        check(nm, v);
    endtask

    initial begin
        for (int k = 0; k < 10; k++) begin
            add_i[k]   = 32'h1000 + 32'(k) * 32'h100;
            wen_i[k]   = k[0];
            be_i[k]    = 4'(k + 1);
            wdata_i[k] = 32'hD000_0000 + 32'(k);
        end
        add_i[3] = 32'h10;
        wen_i[3] = 1'b0;

        //              req     g     rv    rdata         e_gnt   e_rv    mreq  id    busy  err
        vecs[0]  = mk(10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[1]  = mk(10'h008, 1'b1, 1'b0, 32'h0,        10'h008, 10'h000, 1'b1, 4'd3, 1'b0, 1'b0);
        vecs[2]  = mk(10'h000, 1'b0, 1'b1, 32'hA5,       10'h000, 10'h008, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[3]  = mk(10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[4]  = mk(10'h005, 1'b1, 1'b0, 32'h0,        10'h001, 10'h000, 1'b1, 4'd0, 1'b0, 1'b0);
        vecs[5]  = mk(10'h005, 1'b1, 1'b1, 32'h11,       10'h004, 10'h001, 1'b1, 4'd2, 1'b1, 1'b0);
        vecs[6]  = mk(10'h005, 1'b1, 1'b1, 32'h22,       10'h001, 10'h004, 1'b1, 4'd0, 1'b1, 1'b0);
        vecs[7]  = mk(10'h005, 1'b1, 1'b1, 32'h33,       10'h004, 10'h001, 1'b1, 4'd2, 1'b1, 1'b0);
        vecs[8]  = mk(10'h200, 1'b1, 1'b1, 32'h44,       10'h200, 10'h004, 1'b1, 4'd9, 1'b1, 1'b0);
        vecs[9]  = mk(10'h000, 1'b0, 1'b1, 32'h55,       10'h000, 10'h200, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[10] = mk(10'h020, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b1, 4'd5, 1'b0, 1'b0);
        vecs[11] = mk(10'h022, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b1, 4'd5, 1'b0, 1'b0);
        vecs[12] = mk(10'h022, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b1, 4'd5, 1'b0, 1'b0);
        vecs[13] = mk(10'h022, 1'b1, 1'b0, 32'h0,        10'h020, 10'h000, 1'b1, 4'd5, 1'b0, 1'b0);
        vecs[14] = mk(10'h002, 1'b1, 1'b0, 32'h0,        10'h002, 10'h000, 1'b1, 4'd1, 1'b1, 1'b0);
        vecs[15] = mk(10'h000, 1'b0, 1'b1, 32'h66,       10'h000, 10'h020, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[16] = mk(10'h000, 1'b0, 1'b1, 32'h77,       10'h000, 10'h002, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[17] = mk(10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0);
        vecs[18] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h004, 10'h000, 1'b1, 4'd2, 1'b0, 1'b0);
        vecs[19] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h010, 10'h000, 1'b1, 4'd4, 1'b1, 1'b0);
        vecs[20] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h004, 10'h000, 1'b1, 4'd2, 1'b1, 1'b0);
        vecs[21] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h010, 10'h000, 1'b1, 4'd4, 1'b1, 1'b0);
        vecs[22] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h000, 10'h000, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[23] = mk(10'h014, 1'b1, 1'b1, 32'h88,       10'h000, 10'h004, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[24] = mk(10'h014, 1'b1, 1'b0, 32'h0,        10'h004, 10'h000, 1'b1, 4'd2, 1'b1, 1'b0);
        vecs[25] = mk(10'h000, 1'b0, 1'b1, 32'h99,       10'h000, 10'h010, 1'b0, 4'd0, 1'b1, 1'b0);
        vecs[26] = mk(10'h080, 1'b0, 1'b0, 32'h0,        10'h000, 10'h000, 1'b1, 4'd7, 1'b1, 1'b0);

        rst_i = 1'b1;
        drive(10'h000, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset with three tags outstanding and a lock on requester 7.
        rst_i = 1'b1;
        #1;
        cmp("rst_mid.busy", 32'(busy_o), 32'd0);
        cmp("rst_mid.err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run("post_rst_nolock", mk(10'h140, 1'b0, 1'b0, 32'h0, 10'h000, 10'h000, 1'b1, 4'd6, 1'b0, 1'b0));
        run("post_rst_gnt",    mk(10'h140, 1'b1, 1'b0, 32'h0, 10'h040, 10'h000, 1'b1, 4'd6, 1'b0, 1'b0));
        run("post_rst_rsp",    mk(10'h000, 1'b0, 1'b1, 32'h5A, 10'h000, 10'h040, 1'b0, 4'd0, 1'b1, 1'b0));

        // Orphan response: no routing, sticky error until reset.
        run("orphan",          mk(10'h000, 1'b0, 1'b1, 32'hBAD, 10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0));
        run("err_sticky0",     mk(10'h000, 1'b0, 1'b0, 32'h0, 10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b1));
        run("err_sticky_gnt",  mk(10'h100, 1'b1, 1'b0, 32'h0, 10'h100, 10'h000, 1'b1, 4'd8, 1'b0, 1'b1));
        run("err_sticky_rsp",  mk(10'h000, 1'b0, 1'b1, 32'h3C, 10'h000, 10'h100, 1'b0, 4'd0, 1'b1, 1'b1));
        rst_i = 1'b1;
        #1;
        cmp("err_clr_by_rst", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run("idle_after_rst",  mk(10'h000, 1'b0, 1'b0, 32'h0, 10'h000, 10'h000, 1'b0, 4'd0, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
